// File: rtl/instr_execute_unit.sv
// instr_execute_unit
// Single-cycle execute stage for a small 8-bit machine. It consumes the
// 24-bit instruction word from the fetch stage and returns the branch request
// (PCSrc, immediate) that steers the PC. It holds a 4x8-bit register file,
// the Z/C flags, an 8-bit output port and a shift-add multiplier. Multi-cycle
// work (MUL) and HALT hold the PC by requesting a branch to the current PC.
//
// Ports:
//   CLK        in   1   system clock, all state updates on rising edge
//   nReset     in   1   asynchronous active-low reset
//   instr      in   24  current instruction (combinational from ROM at pc)
//   pc         in   8   current PC from the fetch stage
//   PCSrc      out  1   1 = fetch loads immediate next edge, 0 = PC+1
//   immediate  out  8   branch target
//   out_port   out  8   registered output port
//   busy       out  1   multiplier in progress
//   halted     out  1   HALT executed

module instr_execute_unit (
  input  logic        CLK,
  input  logic        nReset,
  input  logic [23:0] instr,
  input  logic [7:0]  pc,
  output logic        PCSrc,
  output logic [7:0]  immediate,
  output logic [7:0]  out_port,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state;
  logic [7:0]  regs [4];
  logic        z_flag;
  logic        c_flag;

  // Multiplier working registers; mul_rd remembers the destination so the
  // write-back does not depend on the instruction still being presented.
  logic [15:0] acc;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [2:0]  cnt;
  logic [1:0]  mul_rd;

  logic [3:0]  opcode;
  logic [1:0]  rd_idx;
  logic [1:0]  rs_idx;
  logic [7:0]  imm;
  logic [7:0]  rd_val;
  logic [7:0]  rs_val;

  logic [7:0]  alu_res;
  logic        alu_c;
  logic        alu_we;
  logic        flag_we;

  logic [15:0] mul_addend;
  logic [15:0] acc_next;
  logic        mul_last;

  // Bits [15:8] of the instruction carry no meaning for this machine.
  logic        unused_instr_bits;

  assign opcode            = instr[23:20];
  assign rd_idx            = instr[19:18];
  assign rs_idx            = instr[17:16];
  assign imm               = instr[7:0];
  assign unused_instr_bits = ^instr[15:8];

  assign rd_val = regs[rd_idx];
  assign rs_val = regs[rs_idx];

  // Single-cycle ALU. The 9-bit add/subtract puts the carry (or, for SUB,
  // the borrow when rd < rs unsigned) into bit 8.
  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    alu_we  = 1'b0;
    flag_we = 1'b0;
    case (opcode)
      OP_LDI: begin
        alu_res = imm;
        alu_we  = 1'b1;
      end
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, rd_val} + {1'b0, rs_val};
        alu_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_SUB: begin
        {alu_c, alu_res} = {1'b0, rd_val} - {1'b0, rs_val};
        alu_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_AND: begin
        alu_res = rd_val & rs_val;
        alu_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_OR: begin
        alu_res = rd_val | rs_val;
        alu_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_XOR: begin
        alu_res = rd_val ^ rs_val;
        alu_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_ADDI: begin
        {alu_c, alu_res} = {1'b0, rd_val} + {1'b0, imm};
        alu_we  = 1'b1;
        flag_we = 1'b1;
      end
      default: begin
        alu_res = 8'h00;
      end
    endcase
  end

  // One shift-add step; on the eighth step (cnt==7) acc_next is the product.
  assign mul_addend = mplier[0] ? mcand : 16'h0000;
  assign acc_next   = acc + mul_addend;
  assign mul_last   = (cnt == 3'd7);

  // Branch request. MUL and HALT freeze fetch by branching to the current pc;
  // the multiplier releases the PC on its final step so the next instruction
  // is fetched in the same edge that writes the product back.
  always_comb begin
    PCSrc     = 1'b0;
    immediate = imm;
    case (state)
      ST_HALT: begin
        PCSrc     = 1'b1;
        immediate = pc;
      end
      ST_MUL: begin
        if (!mul_last) begin
          PCSrc     = 1'b1;
          immediate = pc;
        end
      end
      default: begin
        case (opcode)
          OP_MUL, OP_HALT: begin
            PCSrc     = 1'b1;
            immediate = pc;
          end
          OP_JMP:  PCSrc = 1'b1;
          OP_JZ:   PCSrc = z_flag;
          OP_JC:   PCSrc = c_flag;
          default: PCSrc = 1'b0;
        endcase
      end
    endcase
  end

  // Main state machine: executes single-cycle ops in IDLE, steps the
  // multiplier in MUL, and parks in HALT until reset. Reset abandons any
  // multiply in flight without writing the destination register.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state    <= ST_IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      z_flag   <= 1'b0;
      c_flag   <= 1'b0;
      out_port <= 8'h00;
      acc      <= 16'h0000;
      mcand    <= 16'h0000;
      mplier   <= 8'h00;
      cnt      <= 3'd0;
      mul_rd   <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (opcode == OP_MUL) begin
            acc    <= 16'h0000;
            mcand  <= {8'h00, rd_val};
            mplier <= rs_val;
            cnt    <= 3'd0;
            mul_rd <= rd_idx;
            state  <= ST_MUL;
          end else if (opcode == OP_HALT) begin
            state <= ST_HALT;
          end else begin
            if (alu_we) regs[rd_idx] <= alu_res;
            if (flag_we) begin
              z_flag <= (alu_res == 8'h00);
              c_flag <= alu_c;
            end
            if (opcode == OP_OUT) out_port <= rd_val;
          end
        end
        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          if (mul_last) begin
            regs[mul_rd] <= acc_next[7:0];
            z_flag       <= (acc_next[7:0] == 8'h00);
            c_flag       <= |acc_next[15:8];
            cnt          <= 3'd0;
            state        <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state == ST_MUL);
  assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_instr_execute_unit.sv
// tb_instr_execute_unit
// Bench for instr_execute_unit. A small fetch-stage model (PC register plus
// instruction ROM) closes the loop around the execute unit. Directed programs
// are loaded into the ROM; the stimulus process pushes expected observations
// tagged with the cycle they are due, and an independent monitor pops and
// compares them on the falling clock edge.

module tb_instr_execute_unit;

  localparam int K_PC     = 0;
  localparam int K_PCSRC  = 1;
  localparam int K_IMM    = 2;
  localparam int K_OUT    = 3;
  localparam int K_BUSY   = 4;
  localparam int K_HALTED = 5;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [7:0]  val;
    string       name;
  } exp_t;

  logic        CLK;
  logic        nReset;
  logic [23:0] instr;
  logic [7:0]  pc;
  logic        PCSrc;
  logic [7:0]  immediate;
  logic [7:0]  out_port;
  logic        busy;
  logic        halted;

  logic [23:0] rom [256];
  int unsigned cyc;
  int unsigned base;
  int          checks;
  int          errors;
  exp_t        sb[$];
  exp_t        mon_e;

  instr_execute_unit dut (
    .CLK       (CLK),
    .nReset    (nReset),
    .instr     (instr),
    .pc        (pc),
    .PCSrc     (PCSrc),
    .immediate (immediate),
    .out_port  (out_port),
    .busy      (busy),
    .halted    (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Fetch stage model: reset from ~nReset, loads immediate when PCSrc is set.
  always @(posedge CLK or negedge nReset) begin
    if (!nReset) pc <= 8'h00;
    else         pc <= PCSrc ? immediate : pc + 8'h01;
  end

  assign instr = rom[pc];

  task automatic check_output(input exp_t e);
    logic [7:0] act;
    case (e.kind)
      K_PC:     act = pc;
      K_PCSRC:  act = {7'b0, PCSrc};
      K_IMM:    act = immediate;
      K_OUT:    act = out_port;
      K_BUSY:   act = {7'b0, busy};
      default:  act = {7'b0, halted};
    endcase
    checks++;
    if (e.cyc != cyc) begin
      errors++;
      $display("[TB] FAIL %s: check due at cycle %0d evaluated at cycle %0d", e.name, e.cyc, cyc);
    end else if (act !== e.val) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h (cycle %0d)", e.name, act, e.val, cyc);
    end
  endtask

  // Monitor: compares every expectation that has come due this cycle.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check_output(mon_e);
    end
  end

  task automatic push_exp(input int unsigned at, input int kind, input logic [7:0] val, input string name);
    exp_t e;
    e.cyc  = at;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_at(input int k, input int kind, input logic [7:0] val, input string name);
    push_exp(base + k, kind, val, name);
  endtask

  // Called at posedge+1: asserts reset and expects the asynchronous clear to
  // be visible at the falling edge of this same cycle.
  task automatic assert_reset_now();
    nReset = 1'b0;
    push_exp(cyc, K_BUSY,   8'h00, "rst_busy");
    push_exp(cyc, K_HALTED, 8'h00, "rst_halted");
    push_exp(cyc, K_OUT,    8'h00, "rst_out_port");
  endtask

  task automatic apply_stimulus_reset();
    @(posedge CLK);
    #1;
    assert_reset_now();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge CLK);
    #1;
    nReset = 1'b1;
    base = cyc;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 24'h000000;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (sb.size() > 0 && n < limit) begin
      @(posedge CLK);
      n++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d checks pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    nReset = 1'b0;
    checks = 0;
    errors = 0;
    base   = 0;
    clear_rom();

    // Program 1: add with wrap, OUT, JC taken, JZ not taken, HALT forever.
    apply_stimulus_reset();
    clear_rom();
    rom[8'h00] = 24'h1000F0;  // LDI r0,0xF0
    rom[8'h01] = 24'h140020;  // LDI r1,0x20
    rom[8'h02] = 24'h210000;  // ADD r0,r1
    rom[8'h03] = 24'hC00000;  // OUT r0
    rom[8'h04] = 24'hA00010;  // JC 0x10
    rom[8'h10] = 24'h900020;  // JZ 0x20
    rom[8'h11] = 24'hF00000;  // HALT
    release_reset();
    $display("[TB] program 1: add/wrap/halt");
    expect_at(0,  K_PC,     8'h00, "p1_start_pc");
    expect_at(0,  K_BUSY,   8'h00, "p1_start_busy");
    expect_at(3,  K_OUT,    8'h00, "p1_out_before");
    expect_at(4,  K_PC,     8'h04, "p1_pc4");
    expect_at(4,  K_OUT,    8'h10, "p1_out_sum");
    expect_at(4,  K_PCSRC,  8'h01, "p1_jc_taken");
    expect_at(4,  K_IMM,    8'h10, "p1_jc_target");
    expect_at(5,  K_PC,     8'h10, "p1_pc_branch");
    expect_at(5,  K_PCSRC,  8'h00, "p1_jz_not_taken");
    expect_at(6,  K_PC,     8'h11, "p1_pc_halt");
    expect_at(6,  K_HALTED, 8'h00, "p1_halted_pre");
    expect_at(6,  K_PCSRC,  8'h01, "p1_halt_hold");
    expect_at(6,  K_IMM,    8'h11, "p1_halt_imm");
    expect_at(7,  K_HALTED, 8'h01, "p1_halted");
    expect_at(7,  K_PC,     8'h11, "p1_pc_frozen");
    expect_at(30, K_PC,     8'h11, "p1_pc_frozen_late");
    expect_at(30, K_HALTED, 8'h01, "p1_halted_late");
    expect_at(30, K_OUT,    8'h10, "p1_out_held");
    wait_drain(200);

    // Program 2: SUB to zero then JZ taken; nonzero SUB then JZ not taken.
    apply_stimulus_reset();
    clear_rom();
    rom[8'h00] = 24'h180005;  // LDI r2,5
    rom[8'h01] = 24'h3A0000;  // SUB r2,r2
    rom[8'h02] = 24'h900040;  // JZ 0x40
    rom[8'h40] = 24'h1C0007;  // LDI r3,7
    rom[8'h41] = 24'h3E0000;  // SUB r3,r2
    rom[8'h42] = 24'h900060;  // JZ 0x60
    rom[8'h43] = 24'hCC0000;  // OUT r3
    rom[8'h44] = 24'hF00000;  // HALT
    release_reset();
    $display("[TB] program 2: sub/jz");
    expect_at(0, K_HALTED, 8'h00, "p2_halted_cleared");
    expect_at(2, K_PCSRC,  8'h01, "p2_jz_taken");
    expect_at(2, K_IMM,    8'h40, "p2_jz_target");
    expect_at(3, K_PC,     8'h40, "p2_pc_0x40");
    expect_at(5, K_PC,     8'h42, "p2_pc_0x42");
    expect_at(5, K_PCSRC,  8'h00, "p2_jz_not_taken");
    expect_at(6, K_PC,     8'h43, "p2_pc_inc");
    expect_at(7, K_OUT,    8'h07, "p2_out_r3");
    wait_drain(200);

    // Program 3: 13*11 then 0x20*0x10 with flag-driven branches.
    apply_stimulus_reset();
    clear_rom();
    rom[8'h00] = 24'h10000D;  // LDI r0,13
    rom[8'h01] = 24'h14000B;  // LDI r1,11
    rom[8'h02] = 24'hB10000;  // MUL r0,r1
    rom[8'h03] = 24'hC00000;  // OUT r0
    rom[8'h04] = 24'hA00008;  // JC 0x08
    rom[8'h05] = 24'h100020;  // LDI r0,0x20
    rom[8'h06] = 24'h140010;  // LDI r1,0x10
    rom[8'h07] = 24'hB10000;  // MUL r0,r1
    rom[8'h08] = 24'h90000B;  // JZ 0x0B
    rom[8'h09] = 24'hF00000;  // HALT
    rom[8'h0B] = 24'hA0000E;  // JC 0x0E
    rom[8'h0E] = 24'hC00000;  // OUT r0
    rom[8'h0F] = 24'hF00000;  // HALT
    release_reset();
    $display("[TB] program 3: multiply");
    expect_at(2,  K_PCSRC, 8'h01, "p3_mul_hold");
    expect_at(2,  K_IMM,   8'h02, "p3_mul_imm");
    expect_at(2,  K_BUSY,  8'h00, "p3_busy_pre");
    expect_at(3,  K_BUSY,  8'h01, "p3_busy_first");
    expect_at(3,  K_PC,    8'h02, "p3_pc_frozen_first");
    expect_at(9,  K_PCSRC, 8'h01, "p3_hold_cnt6");
    expect_at(10, K_PC,    8'h02, "p3_pc_frozen_last");
    expect_at(10, K_BUSY,  8'h01, "p3_busy_last");
    expect_at(10, K_PCSRC, 8'h00, "p3_release");
    expect_at(11, K_PC,    8'h03, "p3_pc_resume");
    expect_at(11, K_BUSY,  8'h00, "p3_busy_done");
    expect_at(12, K_OUT,   8'h8F, "p3_product");
    expect_at(12, K_PCSRC, 8'h00, "p3_jc_no_carry");
    expect_at(24, K_PC,    8'h08, "p3_pc_after_mul2");
    expect_at(24, K_PCSRC, 8'h01, "p3_jz_zero_prod");
    expect_at(25, K_PCSRC, 8'h01, "p3_jc_high_byte");
    expect_at(26, K_PC,    8'h0E, "p3_pc_0x0e");
    expect_at(27, K_OUT,   8'h00, "p3_product_low0");
    wait_drain(200);

    // Program 4: rerun the multiply and reset on MUL cycle 4.
    apply_stimulus_reset();
    release_reset();
    $display("[TB] program 4: reset during multiply");
    expect_at(3, K_BUSY, 8'h01, "p4_busy_started");
    expect_at(5, K_BUSY, 8'h01, "p4_busy_cycle3");
    repeat (6) @(posedge CLK);
    #1;
    assert_reset_now();
    push_exp(cyc, K_PC, 8'h00, "p4_pc_reset");
    clear_rom();
    rom[8'h00] = 24'hC40000;  // OUT r1
    rom[8'h01] = 24'h210000;  // ADD r0,r1
    rom[8'h02] = 24'h900005;  // JZ 0x05
    rom[8'h05] = 24'hF00000;  // HALT
    release_reset();
    expect_at(0, K_PC,     8'h00, "p4_restart_pc");
    expect_at(1, K_OUT,    8'h00, "p4_r1_cleared");
    expect_at(2, K_PCSRC,  8'h01, "p4_regs_zero_jz");
    expect_at(2, K_IMM,    8'h05, "p4_jz_target");
    expect_at(4, K_HALTED, 8'h01, "p4_halted");
    wait_drain(200);

    // Program 5: carry survives LDI/OUT/NOP/JMP; logic ops clear it.
    apply_stimulus_reset();
    clear_rom();
    rom[8'h00] = 24'h1000FF;  // LDI r0,0xFF
    rom[8'h01] = 24'h140001;  // LDI r1,0x01
    rom[8'h02] = 24'h210000;  // ADD r0,r1
    rom[8'h03] = 24'h180033;  // LDI r2,0x33
    rom[8'h04] = 24'hC80000;  // OUT r2
    rom[8'h05] = 24'h000000;  // NOP
    rom[8'h06] = 24'h800010;  // JMP 0x10
    rom[8'h10] = 24'hA00020;  // JC 0x20
    rom[8'h20] = 24'h4A0000;  // AND r2,r2
    rom[8'h21] = 24'hA00030;  // JC 0x30
    rom[8'h22] = 24'h780010;  // ADDI r2,0x10
    rom[8'h23] = 24'h590000;  // OR r2,r1
    rom[8'h24] = 24'h690000;  // XOR r2,r1
    rom[8'h25] = 24'hC80000;  // OUT r2
    rom[8'h26] = 24'hF00000;  // HALT
    release_reset();
    $display("[TB] program 5: flag preservation");
    expect_at(6,  K_OUT,    8'h33, "p5_out_r2");
    expect_at(6,  K_PCSRC,  8'h01, "p5_jmp");
    expect_at(6,  K_IMM,    8'h10, "p5_jmp_target");
    expect_at(7,  K_PC,     8'h10, "p5_pc_0x10");
    expect_at(7,  K_PCSRC,  8'h01, "p5_jc_preserved");
    expect_at(7,  K_IMM,    8'h20, "p5_jc_target");
    expect_at(8,  K_PC,     8'h20, "p5_pc_0x20");
    expect_at(9,  K_PCSRC,  8'h00, "p5_and_clears_c");
    expect_at(13, K_PC,     8'h25, "p5_pc_0x25");
    expect_at(14, K_OUT,    8'h42, "p5_logic_chain");
    expect_at(15, K_HALTED, 8'h01, "p5_halted");
    wait_drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
